// File: rtl/mips_wb_pkg.sv
// Shared constants and the retire FSM encoding for the write-back stage.
package mips_wb_pkg;

    localparam logic [4:0]  REG_V0   = 5'd2;
    localparam logic [4:0]  REG_A0   = 5'd4;
    localparam logic [31:0] SYS_HALT = 32'd10;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } state_t;

endpackage

// File: rtl/wb_retire_unit_if.sv
// MEM_WB register outputs as seen by the retire stage.
// Handshake: syscall|WE marks a valid retiring instruction; the unit's go output is the
// ready for the MEM_WB buffer, which holds its contents whenever go is low.
interface wb_retire_unit_if;
    logic        syscall;
    logic        WE;
    logic [4:0]  RW;
    logic [31:0] A;
    logic [31:0] w;

    modport master (output syscall, WE, RW, A, w);
    modport slave  (input  syscall, WE, RW, A, w);
endinterface

// File: rtl/wb_retire_unit_regfile.sv
// 32x32 register file: one synchronous write port, two async reads, v0/a0 taps.
// All read paths forward the in-flight write so readers see this cycle's WB value.
module regfile_2r1w
    import mips_wb_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        we_i,
    input  logic [4:0]  wa_i,
    input  logic [31:0] wd_i,
    input  logic [4:0]  ra1_i,
    input  logic [4:0]  ra2_i,
    output logic [31:0] rd1_o,
    output logic [31:0] rd2_o,
    output logic [31:0] v0_o,
    output logic [31:0] a0_o
);

    logic [31:0] mem_q [32];
    logic        wr_live;

    // reg[0] is hardwired to zero: never written, never forwarded.
    assign wr_live = we_i && (wa_i != 5'd0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_live) begin
            mem_q[wa_i] <= wd_i;
        end
    end

    assign rd1_o = (ra1_i == 5'd0) ? 32'd0 :
                   (wr_live && wa_i == ra1_i) ? wd_i : mem_q[ra1_i];
    assign rd2_o = (ra2_i == 5'd0) ? 32'd0 :
                   (wr_live && wa_i == ra2_i) ? wd_i : mem_q[ra2_i];
    assign v0_o  = (wr_live && wa_i == REG_V0) ? wd_i : mem_q[REG_V0];
    assign a0_o  = (wr_live && wa_i == REG_A0) ? wd_i : mem_q[REG_A0];

endmodule

// File: rtl/wb_retire_unit.sv
// Write-back/retire stage: owns the register file, executes halt/display syscalls,
// drives the global pipeline enable and keeps retire/cycle counters.
module wb_retire_unit
    import mips_wb_pkg::*;
#(
    parameter int CNT_W      = 32,
    parameter int DISP_CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    wb_retire_unit_if.slave       mw,
    input  logic                  resume,
    input  logic [4:0]            ra1,
    input  logic [4:0]            ra2,
    output logic [31:0]           rd1,
    output logic [31:0]           rd2,
    output logic                  go,
    output logic                  halted,
    output logic [31:0]           disp,
    output logic [DISP_CNT_W-1:0] disp_cnt,
    output logic [CNT_W-1:0]      retired,
    output logic [CNT_W-1:0]      cycles,
    output logic [31:0]           trace_a
);

    state_t                state_q;
    logic [CNT_W-1:0]      cycles_q;
    logic [CNT_W-1:0]      retired_q;
    logic [31:0]           disp_q;
    logic [DISP_CNT_W-1:0] disp_cnt_q;
    logic [31:0]           trace_a_q;

    logic        run;
    logic        valid;
    logic [31:0] v0;
    logic [31:0] a0;

    assign run   = (state_q == ST_RUN);
    assign valid = mw.syscall || mw.WE;

    regfile_2r1w u_regfile (
        .clk   (clk),
        .rst_n (rst_n),
        .we_i  (run && mw.WE),
        .wa_i  (mw.RW),
        .wd_i  (mw.w),
        .ra1_i (ra1),
        .ra2_i (ra2),
        .rd1_o (rd1),
        .rd2_o (rd2),
        .v0_o  (v0),
        .a0_o  (a0)
    );

    // While HALTED the MEM_WB buffer is frozen, so nothing retires and nothing counts.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_RUN;
            cycles_q   <= '0;
            retired_q  <= '0;
            disp_q     <= '0;
            disp_cnt_q <= '0;
            trace_a_q  <= '0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    cycles_q <= cycles_q + CNT_W'(1);
                    if (valid) begin
                        retired_q <= retired_q + CNT_W'(1);
                        trace_a_q <= mw.A;
                    end
                    if (mw.syscall) begin
                        if (v0 == SYS_HALT) begin
                            state_q <= ST_HALTED;
                        end else begin
                            disp_q     <= a0;
                            disp_cnt_q <= disp_cnt_q + DISP_CNT_W'(1);
                        end
                    end
                end
                ST_HALTED: begin
                    if (resume) begin
                        state_q <= ST_RUN;
                    end
                end
                default: state_q <= ST_RUN;
            endcase
        end
    end

    assign go       = run;
    assign halted   = (state_q == ST_HALTED);
    assign disp     = disp_q;
    assign disp_cnt = disp_cnt_q;
    assign retired  = retired_q;
    assign cycles   = cycles_q;
    assign trace_a  = trace_a_q;

endmodule
